// File: rtl/sdc_wb_init_sequencer_if.sv
// Wishbone master bus between the init sequencer and the register slave.
//   master: drives adr/dat_o/sel/we/cyc/stb, receives dat_i/ack
//   slave : the mirror image
interface sdc_wb_init_sequencer_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic [ADDR_W-1:0] wb_adr_o;
    logic [DATA_W-1:0] wb_dat_o;
    logic [SEL_W-1:0]  wb_sel_o;
    logic              wb_we_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic [DATA_W-1:0] wb_dat_i;
    logic              wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/sdc_wb_init_sequencer.sv
// Walks an external register-init table and writes each entry over Wishbone,
// optionally reading it back under a mask with bounded rewrites.
//   clk, reset_n          : clock, async active-low reset
//   start, abort          : launch / cancel a sequence
//   tbl_idx -> tbl_*      : index into an external combinational table
//   wb (master)           : Wishbone bus
//   busy, done, fail      : sequence status; fail_code/fail_idx explain a failure
//   rd_data               : last readback value
module sdc_wb_init_sequencer #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_ENTRIES = 12,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned VERIFY_EN   = 1,
    parameter int unsigned RETRY_MAX   = 2,
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [IDX_W-1:0]      tbl_idx,
    input  logic [ADDR_W-1:0]     tbl_adr,
    input  logic [DATA_W-1:0]     tbl_dat,
    input  logic [DATA_W/8-1:0]   tbl_sel,
    input  logic [DATA_W-1:0]     tbl_mask,
    input  logic                  tbl_last,
    sdc_wb_init_sequencer_if.master wb,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [1:0]            fail_code,
    output logic [IDX_W-1:0]      fail_idx,
    output logic [DATA_W-1:0]     rd_data
);
    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned RTY_W = $clog2(RETRY_MAX + 2);

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_TIMEOUT = 2'd1;
    localparam logic [1:0] FC_VERIFY  = 2'd2;
    localparam logic [1:0] FC_ABORT   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WR, S_RD, S_NEXT, S_DONE, S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [ADDR_W-1:0]  adr_q, adr_d;
    logic [DATA_W-1:0]  dat_q, dat_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0]  mask_q, mask_d;
    logic               last_q, last_d;
    logic               cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic               busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic [1:0]         code_q, code_d;
    logic [IDX_W-1:0]   fidx_q, fidx_d;
    logic [DATA_W-1:0]  rd_q, rd_d;

    logic               active, timeout, verify_ok, go_fail;
    logic [1:0]         go_code;

    // State and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            retry_q <= '0;
            timer_q <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= FC_NONE;
            fidx_q  <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            timer_q <= timer_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
            fidx_q  <= fidx_d;
            rd_q    <= rd_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        timer_d = stb_q ? timer_q + TMR_W'(1) : timer_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        mask_d  = mask_q;
        last_d  = last_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        busy_d  = busy_q;
        done_d  = done_q;
        fail_d  = fail_q;
        code_d  = code_q;
        fidx_d  = fidx_q;
        rd_d    = rd_q;
        go_fail = 1'b0;
        go_code = FC_NONE;

        active    = (state_q == S_LOAD) || (state_q == S_WR) ||
                    (state_q == S_RD)   || (state_q == S_NEXT);
        timeout   = stb_q && (timer_q == TMR_W'(ACK_TIMEOUT - 1));
        verify_ok = (wb.wb_dat_i & mask_q) == (dat_q & mask_q);

        if (active && abort) begin
            go_fail = 1'b1;
            go_code = FC_ABORT;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        idx_d   = '0;
                        retry_d = '0;
                        done_d  = 1'b0;
                        fail_d  = 1'b0;
                        code_d  = FC_NONE;
                        busy_d  = 1'b1;
                        state_d = S_LOAD;
                    end
                end
                // Latch the entry and launch the write on the same edge
                S_LOAD: begin
                    adr_d   = tbl_adr;
                    dat_d   = tbl_dat;
                    sel_d   = tbl_sel;
                    mask_d  = tbl_mask;
                    last_d  = tbl_last;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    timer_d = '0;
                    state_d = S_WR;
                end
                // stb low here only on a rewrite, which follows a read
                S_WR: begin
                    if (!stb_q) begin
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = 1'b1;
                        timer_d = '0;
                    end else if (wb.wb_ack_i) begin
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        we_d    = 1'b0;
                        state_d = ((VERIFY_EN != 0) && (mask_q != '0)) ? S_RD : S_NEXT;
                    end else if (timeout) begin
                        go_fail = 1'b1;
                        go_code = FC_TIMEOUT;
                    end
                end
                // Entered with stb low, giving an idle cycle before the read
                S_RD: begin
                    if (!stb_q) begin
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = 1'b0;
                        timer_d = '0;
                    end else if (wb.wb_ack_i) begin
                        rd_d  = wb.wb_dat_i;
                        cyc_d = 1'b0;
                        stb_d = 1'b0;
                        if (verify_ok) begin
                            state_d = S_NEXT;
                        end else if (retry_q < RTY_W'(RETRY_MAX)) begin
                            retry_d = retry_q + RTY_W'(1);
                            state_d = S_WR;
                        end else begin
                            go_fail = 1'b1;
                            go_code = FC_VERIFY;
                        end
                    end else if (timeout) begin
                        go_fail = 1'b1;
                        go_code = FC_TIMEOUT;
                    end
                end
                S_NEXT: begin
                    if (last_q || (idx_q == IDX_W'(NUM_ENTRIES - 1))) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        retry_d = '0;
                        state_d = S_LOAD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Common failure exit: release the bus and record where it happened
        if (go_fail) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            fail_d  = 1'b1;
            code_d  = go_code;
            fidx_d  = idx_q;
            state_d = S_FAIL;
        end
    end

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = stb_q;

    assign tbl_idx   = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_code = code_q;
    assign fail_idx  = fidx_q;
    assign rd_data   = rd_q;
endmodule

// File: tb/tb_sdc_wb_init_sequencer.sv
// Bench for sdc_wb_init_sequencer: directed scenarios plus randomized tables,
// checked against a transaction-level reference model of the init sequence.
module tb_sdc_wb_init_sequencer;
    localparam int NUM  = 12;
    localparam int RMAX = 2;
    localparam int TMO  = 15;

    typedef struct packed {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } tx_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start, abort;
    logic [3:0]  tbl_idx;
    logic [7:0]  tbl_adr;
    logic [31:0] tbl_dat, tbl_mask;
    logic [3:0]  tbl_sel;
    logic        tbl_last;
    logic        busy, done, fail;
    logic [1:0]  fail_code;
    logic [3:0]  fail_idx;
    logic [31:0] rd_data;

    sdc_wb_init_sequencer_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    // External combinational table
    logic [7:0]  t_adr  [16];
    logic [31:0] t_dat  [16];
    logic [3:0]  t_sel  [16];
    logic [31:0] t_mask [16];
    logic        t_last [16];
    assign tbl_adr  = t_adr[tbl_idx];
    assign tbl_dat  = t_dat[tbl_idx];
    assign tbl_sel  = t_sel[tbl_idx];
    assign tbl_mask = t_mask[tbl_idx];
    assign tbl_last = t_last[tbl_idx];

    // Slave: byte-lane register file, ack after 'lat' extra strobe cycles
    int          lat;
    bit          noack, ack_force, force_en, mem_load;
    logic [31:0] force_val;
    logic [31:0] mem [256];
    logic [31:0] seed [256];
    logic [31:0] m_mem [256];
    int          cnt;
    tx_t         obs_q [$];
    tx_t         exp_q [$];

    assign bus.wb_dat_i = force_en ? force_val : mem[bus.wb_adr_o];
    assign bus.wb_ack_i = ack_force |
                          (bus.wb_cyc_o & bus.wb_stb_o & ~noack & (cnt >= lat));

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed[i];
        end else if (reset_n && bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i) begin
            if (bus.wb_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.wb_sel_o[b]) mem[bus.wb_adr_o][8*b +: 8] <= bus.wb_dat_o[8*b +: 8];
                obs_q.push_back(tx_t'{1'b1, bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o});
            end else begin
                obs_q.push_back(tx_t'{1'b0, bus.wb_adr_o, bus.wb_dat_i, bus.wb_sel_o});
            end
        end
        if (!reset_n || !bus.wb_stb_o) cnt <= 0;
        else if (!bus.wb_ack_i)        cnt <= cnt + 1;
    end

    sdc_wb_init_sequencer #(
        .ADDR_W(8), .DATA_W(32), .NUM_ENTRIES(NUM), .IDX_W(4),
        .VERIFY_EN(1), .RETRY_MAX(RMAX), .ACK_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .tbl_idx(tbl_idx), .tbl_adr(tbl_adr), .tbl_dat(tbl_dat),
        .tbl_sel(tbl_sel), .tbl_mask(tbl_mask), .tbl_last(tbl_last),
        .wb(bus), .busy(busy), .done(done), .fail(fail),
        .fail_code(fail_code), .fail_idx(fail_idx), .rd_data(rd_data)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected transactions, outcome and edge count
    bit          e_done, e_fail, have_rd;
    logic [1:0]  e_code;
    int          e_fidx, e_cycles;
    logic [31:0] e_rd;
    int          last_n, last_ntx;

    task automatic model_run();
        logic [31:0] v;
        bit ok;
        exp_q.delete();
        e_done = 0; e_fail = 0; e_code = 2'd0; e_fidx = 0; e_cycles = 0; have_rd = 0;
        for (int i = 0; i < NUM; i++) begin
            ok = 0;
            e_cycles += 1;
            for (int a = 0; a <= RMAX; a++) begin
                e_cycles += (a == 0) ? lat + 1 : lat + 2;
                exp_q.push_back(tx_t'{1'b1, t_adr[i], t_dat[i], t_sel[i]});
                for (int b = 0; b < 4; b++)
                    if (t_sel[i][b]) m_mem[t_adr[i]][8*b +: 8] = t_dat[i][8*b +: 8];
                if (t_mask[i] == 32'd0) begin ok = 1; break; end
                v = force_en ? force_val : m_mem[t_adr[i]];
                e_cycles += lat + 2;
                exp_q.push_back(tx_t'{1'b0, t_adr[i], v, t_sel[i]});
                e_rd = v;
                have_rd = 1;
                if ((v & t_mask[i]) == (t_dat[i] & t_mask[i])) begin ok = 1; break; end
            end
            if (!ok) begin
                e_fail = 1; e_code = 2'd2; e_fidx = i;
                return;
            end
            e_cycles += 1;
            if (t_last[i] || i == NUM - 1) begin
                e_done = 1;
                return;
            end
        end
    endtask

    task automatic trial(input string tag, input bit do_load);
        int base, n, max_idx;
        bit to;
        for (int i = 0; i < 256; i++) m_mem[i] = seed[i];
        if (do_load) begin
            mem_load = 1; step(); mem_load = 0;
        end
        model_run();
        base = obs_q.size();
        start = 1; step(); start = 0;
        check({tag, "_launch"}, 64'({busy, tbl_idx}), 64'({1'b1, 4'd0}));
        n = 0; max_idx = 0; to = 0;
        while (!(done || fail)) begin
            if (n >= 2000) begin to = 1; break; end
            step();
            n++;
            if (int'(tbl_idx) > max_idx) max_idx = int'(tbl_idx);
        end
        last_n = n;
        last_ntx = obs_q.size() - base;
        check({tag, "_timeout"}, 64'(to), 64'(0));
        check({tag, "_cycles"}, 64'(n), 64'(e_cycles));
        check({tag, "_status"}, 64'({busy, done, fail, fail_code, bus.wb_cyc_o}),
              64'({1'b0, e_done, e_fail, e_code, 1'b0}));
        if (e_fail) check({tag, "_fail_idx"}, 64'(fail_idx), 64'(e_fidx));
        if (have_rd) check({tag, "_rd_data"}, 64'(rd_data), 64'(e_rd));
        check({tag, "_ntx"}, 64'(last_ntx), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < obs_q.size())
                check({tag, "_tx"}, 64'(obs_q[base + i]), 64'(exp_q[i]));
        check({tag, "_idx_bound"}, 64'(max_idx <= NUM - 1), 64'(1));
        step();
        check({tag, "_hold"}, 64'({done, fail}), 64'({e_done, e_fail}));
    endtask

    task automatic clear_table();
        for (int i = 0; i < 16; i++) begin
            t_adr[i] = 8'd0; t_dat[i] = 32'd0; t_sel[i] = 4'hF;
            t_mask[i] = 32'd0; t_last[i] = 1'b0;
        end
    endtask

    initial begin
        int n, stbc, base, r, n_ent;
        bit found;
        reset_n = 0; start = 0; abort = 0;
        lat = 0; noack = 0; ack_force = 0; force_en = 0; force_val = 32'd0; mem_load = 0;
        clear_table();
        for (int i = 0; i < 256; i++) seed[i] = 32'd0;

        // Reset values, then first start right after release
        step(); step();
        check("reset_bus", 64'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_sel_o}), 64'd0);
        check("reset_stat", 64'({busy, done, fail, fail_code, fail_idx, tbl_idx}), 64'd0);
        check("reset_rd", 64'(rd_data), 64'd0);
        t_adr[0] = 8'h10; t_dat[0] = 32'h1111_1111; t_sel[0] = 4'hF;
        t_adr[1] = 8'h14; t_dat[1] = 32'h2222_2222; t_sel[1] = 4'h3;
        t_adr[2] = 8'h20; t_dat[2] = 32'hA5A5_A5A5; t_sel[2] = 4'hC; t_last[2] = 1'b1;
        mem_load = 1; step(); mem_load = 0;
        reset_n = 1;
        trial("s1", 0);
        check("s1_nine_cycles", 64'(last_n), 64'(9));
        check("s1_three_writes", 64'(last_ntx), 64'(3));

        // Single verified entry
        clear_table();
        t_adr[0] = 8'h18; t_dat[0] = 32'h0000_7FFF; t_mask[0] = 32'h0000_FFFF; t_last[0] = 1'b1;
        trial("s2", 1);
        check("s2_rd_data", 64'(rd_data), 64'h7FFF);
        check("s2_wr_rd", 64'(last_ntx), 64'(2));

        // Readback stuck at zero exhausts retries
        force_en = 1; force_val = 32'd0;
        trial("s3", 1);
        check("s3_six_tx", 64'(last_ntx), 64'(6));
        check("s3_fail", 64'({fail, fail_code, fail_idx}), 64'({1'b1, 2'd2, 4'd0}));
        force_en = 0;

        // Slave never acks
        clear_table();
        t_last[0] = 1'b1;
        noack = 1;
        start = 1; step(); start = 0;
        n = 0; stbc = 0;
        while (!fail && n < 100) begin
            step(); n++;
            if (bus.wb_stb_o) stbc++;
        end
        check("tmo_stb_cycles", 64'(stbc), 64'(TMO));
        check("tmo_edges", 64'(n), 64'(TMO + 1));
        check("tmo_fail", 64'({fail, fail_code, fail_idx, bus.wb_cyc_o, bus.wb_stb_o}),
              64'({1'b1, 2'd1, 4'd0, 1'b0, 1'b0}));
        noack = 0;

        // Abort (with simultaneous start) during write of entry 2
        clear_table();
        for (int i = 0; i < 4; i++) begin
            t_adr[i] = 8'(8'h40 + 4 * i); t_dat[i] = 32'(32'hC0DE_0000 + i);
        end
        t_last[3] = 1'b1;
        lat = 2;
        start = 1; step(); start = 0;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (tbl_idx == 4'd2 && bus.wb_stb_o && bus.wb_we_o) found = 1;
            else step();
        end
        check("abort_reached", 64'(found), 64'(1));
        abort = 1; start = 1; step(); abort = 0; start = 0;
        check("abort_bus", 64'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}), 64'd0);
        check("abort_fail", 64'({busy, fail, fail_code, fail_idx}), 64'({1'b0, 1'b1, 2'd3, 4'd2}));
        trial("abort_restart", 1);

        // Reset in the middle of a read; spurious acks afterwards
        clear_table();
        t_adr[0] = 8'h33; t_dat[0] = 32'h1234_5678; t_mask[0] = 32'hFFFF_FFFF; t_last[0] = 1'b1;
        lat = 4;
        start = 1; step(); start = 0;
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (bus.wb_stb_o && !bus.wb_we_o) found = 1;
            else step();
        end
        check("rst_reached_rd", 64'(found), 64'(1));
        #3 reset_n = 0;
        #1;
        check("rst_async_bus", 64'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_sel_o}), 64'd0);
        check("rst_async_dat", 64'(bus.wb_dat_o), 64'd0);
        check("rst_async_stat", 64'({busy, done, fail, fail_code, fail_idx, tbl_idx}), 64'd0);
        check("rst_async_rd", 64'(rd_data), 64'd0);
        step();
        reset_n = 1;
        base = obs_q.size();
        ack_force = 1;
        step(); step(); step();
        ack_force = 0;
        check("rst_no_resume", 64'({bus.wb_cyc_o, bus.wb_stb_o, busy, done, fail}), 64'd0);
        check("rst_no_tx", 64'(obs_q.size() - base), 64'd0);

        // Randomized tables, latencies and readback corruption
        for (int t = 0; t < 25; t++) begin
            clear_table();
            n_ent = int'($urandom_range(1, NUM));
            for (int i = 0; i < 16; i++) begin
                t_adr[i] = 8'($urandom);
                t_dat[i] = $urandom;
                t_sel[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                r = int'($urandom_range(0, 3));
                t_mask[i] = (r == 0) ? 32'd0 : (r == 1) ? 32'hFFFF_FFFF :
                            (r == 2) ? $urandom : 32'h0000_FFFF;
            end
            if ($urandom_range(0, 3) != 0) t_last[n_ent - 1] = 1'b1;
            for (int i = 0; i < 256; i++) seed[i] = $urandom;
            lat = int'($urandom_range(0, 3));
            force_en = ($urandom_range(0, 5) == 0);
            force_val = $urandom;
            trial("rand", 1);
            for (int k = int'($urandom_range(0, 3)); k > 0; k--) step();
        end
        force_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/sdc_wb_init_sequencer.md
SDC_WB_INIT_SEQUENCER -- requirements
Module: sdc_wb_init_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  - ADDR_W, 8, Wishbone address width.
  - DATA_W, 32, Wishbone data width.
  - NUM_ENTRIES, 12, number of table entries.
  - IDX_W, 4, table index width; 2^IDX_W >= NUM_ENTRIES.
  - VERIFY_EN, 1, enables readback verify.
  - RETRY_MAX, 2, rewrites allowed per entry on verify mismatch.
  - ACK_TIMEOUT, 1023, cycles without ack before abort.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk, in, 1, sole clock.
  - reset_n, in, 1, asynchronous active-low reset.
  - start, in, 1, begin sequence.
  - abort, in, 1, synchronous cancel.
  - tbl_idx, out, IDX_W, current entry index to the external combinational table.
  - tbl_adr, in, ADDR_W, entry register address.
  - tbl_dat, in, DATA_W, entry write value.
  - tbl_sel, in, DATA_W/8, entry byte select.
  - tbl_mask, in, DATA_W, verify mask; 0 skips verify.
  - tbl_last, in, 1, entry is the final entry.
  - wb_adr_o, out, ADDR_W, Wishbone address.
  - wb_dat_o, out, DATA_W, Wishbone write data.
  - wb_sel_o, out, DATA_W/8, Wishbone byte select.
  - wb_we_o, out, 1, Wishbone write enable.
  - wb_cyc_o, out, 1, Wishbone cycle.
  - wb_stb_o, out, 1, Wishbone strobe.
  - wb_dat_i, in, DATA_W, Wishbone read data.
  - wb_ack_i, in, 1, Wishbone acknowledge.
  - busy, out, 1, sequence in progress.
  - done, out, 1, sequence completed successfully.
  - fail, out, 1, sequence failed.
  - fail_code, out, 2, 0 none, 1 ack timeout, 2 verify mismatch, 3 aborted.
  - fail_idx, out, IDX_W, index of the failing entry.
  - rd_data, out, DATA_W, last readback value.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, WR, RD, NEXT, DONE and FAIL; all outputs SHALL be registered.
REQ-004 start sampled high in IDLE, DONE or FAIL SHALL clear tbl_idx, retry count, done, fail and fail_code, and SHALL enter LOAD; start in any other state SHALL be ignored.
REQ-005 LOAD SHALL last 1 cycle and latch tbl_adr/tbl_dat/tbl_sel/tbl_mask/tbl_last into wb_adr_o/wb_dat_o/wb_sel_o and internal registers, then enter WR.
REQ-006 WR SHALL assert wb_cyc_o=wb_stb_o=wb_we_o=1 on the first edge after entry and hold them until wb_ack_i is sampled high.
REQ-007 On a WR ack, cyc/stb/we SHALL drop on that same edge; if VERIFY_EN=1 and mask!=0 the FSM SHALL enter RD, otherwise NEXT.
REQ-008 RD SHALL assert cyc=stb=1 with we=0 on the first edge after entry, giving at least 1 idle bus cycle between transactions.
REQ-009 On a RD ack, rd_data SHALL capture wb_dat_i and cyc/stb SHALL drop.
REQ-010 Verify compare is (wb_dat_i & mask) == (latched dat & mask):
  - match: enter NEXT.
  - mismatch with retry count < RETRY_MAX: increment retry count and re-enter WR with the same entry.
  - mismatch otherwise: enter FAIL with fail_code=2.
REQ-011 NEXT SHALL last 1 cycle:
  - if tbl_last (latched) or tbl_idx==NUM_ENTRIES-1: enter DONE.
  - otherwise: increment tbl_idx, clear the retry count, enter LOAD.
REQ-012 The ack timer SHALL clear at each strobe rise and count while stb=1; reaching ACK_TIMEOUT SHALL drop cyc/stb/we and enter FAIL with fail_code=1.
REQ-013 If ack and timer terminal count coincide, ack SHALL win.
REQ-014 abort in any state other than IDLE, DONE or FAIL SHALL drop cyc/stb/we on the same edge and enter FAIL with fail_code=3; abort has priority over start.
REQ-015 busy SHALL be 1 in LOAD, WR, RD and NEXT; done SHALL be 1 only in DONE; fail SHALL be 1 only in FAIL; done and fail SHALL hold until the next start.
REQ-016 fail_idx SHALL equal tbl_idx at the moment of entering FAIL.
REQ-017 wb_ack_i while stb=0 SHALL be ignored.
REQ-018 tbl_idx SHALL never exceed NUM_ENTRIES-1.

Reset
REQ-019 reset_n low SHALL asynchronously force IDLE; all Wishbone outputs, busy, done, fail, fail_code, fail_idx, tbl_idx and rd_data SHALL be 0.
REQ-020 Reset asserted mid-transaction SHALL drop cyc/stb immediately; no cycle SHALL resume after release.
REQ-021 The first start SHALL be honoured on the first edge after reset_n deasserts.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - 3-entry table, mask=0, slave acks after 1 cycle -> 3 writes to correct addr/dat/sel, no reads, done=1, 9 cycles from start to done.
  - Entry 0 adr=0x18, dat=0x7FFF, mask=0xFFFF, slave returns 0x7FFF -> one write then one read, rd_data=0x7FFF, done=1.
  - Slave returns 0x0000 for mask=0xFFFF, RETRY_MAX=2 -> 3 writes and 3 reads, then fail=1, fail_code=2, fail_idx=0.
  - Slave never acks, ACK_TIMEOUT=15 -> stb drops after 15 cycles, fail_code=1.
  - abort during WR of entry 2 -> cyc=0 next edge, fail_code=3, fail_idx=2; a following start restarts from idx 0.
  - reset_n pulsed low mid-RD -> all outputs 0 immediately, spurious ack afterwards ignored.
